// File: rtl/ahb64_sram_ctrl.sv
// AHB-Lite 64-bit slave in front of a single-port synchronous SRAM: zero-wait posted writes,
// reads take 3+WAIT_STATES data-phase cycles (+1 to drain a pending write); bad transfers get a 2-cycle ERROR.
module ahb64_sram_ctrl #(
    parameter int          MEM_AW      = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [63:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [63:0]       HRDATA,
    output logic              sram_en,
    output logic              sram_we,
    output logic [7:0]        sram_wmask,
    output logic [MEM_AW-1:0] sram_addr,
    output logic [63:0]       sram_wdata,
    input  logic [63:0]       sram_rdata
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_WRITE    = 4'd1;
    localparam logic [3:0] S_RD_DRAIN = 4'd2;
    localparam logic [3:0] S_RD_ISSUE = 4'd3;
    localparam logic [3:0] S_RD_WAIT  = 4'd4;
    localparam logic [3:0] S_RD_CAP   = 4'd5;
    localparam logic [3:0] S_RD_DONE  = 4'd6;
    localparam logic [3:0] S_ERR1     = 4'd7;
    localparam logic [3:0] S_ERR2     = 4'd8;

    localparam logic [2:0] WAIT_LAST = 3'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    logic [3:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [MEM_AW-1:0] xfer_addr_q, xfer_addr_d;
    logic [7:0]        xfer_mask_q, xfer_mask_d;
    logic              buf_vld_q, buf_vld_d;
    logic [MEM_AW-1:0] buf_addr_q, buf_addr_d;
    logic [7:0]        buf_mask_q, buf_mask_d;
    logic [63:0]       buf_data_q, buf_data_d;
    logic [63:0]       hrdata_q, hrdata_d;

    logic       hready_int;
    logic       accept;
    logic       window_ok;
    logic       align_ok;
    logic       addr_err;
    logic [7:0] acc_mask;
    logic       drain;

    assign hready_int = (state_q == S_IDLE) || (state_q == S_WRITE) ||
                        (state_q == S_RD_DONE) || (state_q == S_ERR2);
    assign accept     = hready_int && HSEL && HREADY && HTRANS[1];
    assign window_ok  = (HADDR[31:MEM_AW+3] == BASE_ADDR[31:MEM_AW+3]);

    // Oversize transfers fall into the default arm and are reported as misaligned.
    always_comb begin
        align_ok = 1'b0;
        acc_mask = 8'hFF;
        case (HSIZE)
            3'd0: begin align_ok = 1'b1;                  acc_mask = 8'h01 << HADDR[2:0]; end
            3'd1: begin align_ok = ~HADDR[0];             acc_mask = 8'h03 << HADDR[2:0]; end
            3'd2: begin align_ok = (HADDR[1:0] == 2'b00); acc_mask = 8'h0F << HADDR[2:0]; end
            3'd3: begin align_ok = (HADDR[2:0] == 3'b000); acc_mask = 8'hFF; end
            default: begin align_ok = 1'b0;               acc_mask = 8'hFF; end
        endcase
    end

    assign addr_err = !window_ok || !align_ok;

    // The posted write takes the SRAM port in any cycle a read is not issuing.
    assign drain = buf_vld_q && (state_q != S_RD_ISSUE);

    always_comb begin
        buf_vld_d  = buf_vld_q;
        buf_addr_d = buf_addr_q;
        buf_mask_d = buf_mask_q;
        buf_data_d = buf_data_q;
        if (drain) begin
            buf_vld_d = 1'b0;
        end
        if (state_q == S_WRITE) begin
            buf_vld_d  = 1'b1;
            buf_addr_d = xfer_addr_q;
            buf_mask_d = xfer_mask_q;
            buf_data_d = HWDATA;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        xfer_addr_d = xfer_addr_q;
        xfer_mask_d = xfer_mask_q;
        case (state_q)
            S_IDLE, S_WRITE, S_RD_DONE, S_ERR2: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (addr_err) begin
                        state_d = S_ERR1;
                    end else begin
                        xfer_addr_d = HADDR[MEM_AW+2:3];
                        xfer_mask_d = acc_mask;
                        if (HWRITE) begin
                            state_d = S_WRITE;
                        end else begin
                            state_d = buf_vld_d ? S_RD_DRAIN : S_RD_ISSUE;
                        end
                    end
                end
            end
            S_RD_DRAIN: state_d = S_RD_ISSUE;
            S_RD_ISSUE: begin
                cnt_d   = WAIT_LAST;
                state_d = (WAIT_STATES == 0) ? S_RD_CAP : S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_RD_CAP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RD_CAP: state_d = S_RD_DONE;
            S_ERR1:   state_d = S_ERR2;
            default:  state_d = S_IDLE;
        endcase
    end

    assign hrdata_d = (state_q == S_RD_CAP) ? sram_rdata : hrdata_q;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            xfer_addr_q <= '0;
            xfer_mask_q <= '0;
            buf_vld_q   <= 1'b0;
            buf_addr_q  <= '0;
            buf_mask_q  <= '0;
            buf_data_q  <= '0;
            hrdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            xfer_addr_q <= xfer_addr_d;
            xfer_mask_q <= xfer_mask_d;
            buf_vld_q   <= buf_vld_d;
            buf_addr_q  <= buf_addr_d;
            buf_mask_q  <= buf_mask_d;
            buf_data_q  <= buf_data_d;
            hrdata_q    <= hrdata_d;
        end
    end

    assign HREADYOUT  = hready_int;
    assign HRESP      = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign HRDATA     = hrdata_q;
    assign sram_en    = drain || (state_q == S_RD_ISSUE);
    assign sram_we    = drain;
    assign sram_wmask = drain ? buf_mask_q : 8'h00;
    assign sram_addr  = drain ? buf_addr_q : xfer_addr_q;
    assign sram_wdata = buf_data_q;

endmodule

// File: tb/tb_ahb64_sram_ctrl.sv
// Bench for ahb64_sram_ctrl: two instances (WAIT_STATES 0 and 3), each with its own SRAM model,
// checked against a word-array reference memory and latency/error rules computed from the transfer.
module tb_ahb64_sram_ctrl;

    logic        HCLK = 1'b0;
    logic        hreset, hsel0, hsel1, hwrite;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [63:0] hwdata;

    logic        ro0, rs0, en0, we0, ro1, rs1, en1, we1;
    logic [63:0] rd0, wd0, sr0, rd1, wd1, sr1;
    logic [7:0]  wm0, wm1;
    logic [9:0]  sa0, sa1;

    logic [63:0] mem0 [0:1023];
    logic [63:0] mem1 [0:1023];
    logic [63:0] ref0 [0:1023];
    logic [63:0] ref1 [0:1023];
    int          wr_cnt1 = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    initial forever #5 HCLK = ~HCLK;

    ahb64_sram_ctrl #(.WAIT_STATES(0)) u_dut0 (
        .HCLK(HCLK), .HRESET(hreset), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ro0), .HREADYOUT(ro0),
        .HRESP(rs0), .HRDATA(rd0), .sram_en(en0), .sram_we(we0), .sram_wmask(wm0),
        .sram_addr(sa0), .sram_wdata(wd0), .sram_rdata(sr0)
    );

    ahb64_sram_ctrl #(.WAIT_STATES(3)) u_dut1 (
        .HCLK(HCLK), .HRESET(hreset), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ro1), .HREADYOUT(ro1),
        .HRESP(rs1), .HRDATA(rd1), .sram_en(en1), .sram_we(we1), .sram_wmask(wm1),
        .sram_addr(sa1), .sram_wdata(wd1), .sram_rdata(sr1)
    );

    // Synchronous SRAM models: read data appears the cycle after the strobe and holds.
    initial begin
        for (int i = 0; i < 1024; i++) mem0[i] = '0;
        sr0 = '0;
        forever begin
            @(posedge HCLK);
            if (en0) begin
                if (we0) begin
                    for (int b = 0; b < 8; b++) if (wm0[b]) mem0[sa0][b*8 +: 8] = wd0[b*8 +: 8];
                end else begin
                    sr0 <= mem0[sa0];
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem1[i] = '0;
        sr1 = '0;
        forever begin
            @(posedge HCLK);
            if (en1) begin
                if (we1) begin
                    wr_cnt1 <= wr_cnt1 + 1;
                    for (int b = 0; b < 8; b++) if (wm1[b]) mem1[sa1][b*8 +: 8] = wd1[b*8 +: 8];
                end else begin
                    sr1 <= mem1[sa1];
                end
            end
        end
    end

    task automatic apply_ref(input bit inst, input logic [31:0] a, input logic [2:0] sz,
                             input logic [63:0] d);
        int lo, n, idx;
        logic [63:0] w;
        lo  = (sz == 3'd3) ? 0 : int'(a % 8);
        n   = 1 << sz;
        idx = int'((a / 8) % 1024);
        w   = inst ? ref1[idx] : ref0[idx];
        for (int b = 0; b < 8; b++) if (b >= lo && b < lo + n) w[b*8 +: 8] = d[b*8 +: 8];
        if (inst) ref1[idx] = w; else ref0[idx] = w;
    endtask

    // One non-pipelined transfer, started at a negedge; ends one idle cycle after the data phase.
    task automatic xfer(input bit inst, input logic [31:0] a, input bit w, input logic [2:0] sz,
                        input logic [63:0] d, output logic [63:0] rdat, output int cyc,
                        output bit resp_all, output bit resp_any, output int en_cnt);
        logic r, s, e;
        hsel0 = !inst; hsel1 = inst;
        haddr = a; htrans = 2'b10; hwrite = w; hsize = sz;
        @(negedge HCLK);
        hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00; hwdata = d;
        cyc = 0; resp_all = 1'b1; resp_any = 1'b0; en_cnt = 0; rdat = '0;
        while (cyc < 40) begin
            r = inst ? ro1 : ro0;
            s = inst ? rs1 : rs0;
            e = inst ? en1 : en0;
            cyc++;
            resp_all = resp_all && (s === 1'b1);
            resp_any = resp_any || (s !== 1'b0);
            if (e === 1'b1) en_cnt++;
            if (r === 1'b1) begin
                rdat = inst ? rd1 : rd0;
                break;
            end
            @(negedge HCLK);
        end
        @(negedge HCLK);
    endtask

    task automatic test_reset();
        hreset = 1'b1; hsel0 = 0; hsel1 = 0; haddr = '0; htrans = 2'b00;
        hwrite = 0; hsize = 3'd0; hwdata = '0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        n_chk++; if ({ro0, ro1} !== 2'b11) $display("FAIL reset_hreadyout: got %b want 11", {ro0, ro1}); else n_pass++;
        n_chk++; if ({rs0, rs1} !== 2'b00) $display("FAIL reset_hresp: got %b want 00", {rs0, rs1}); else n_pass++;
        n_chk++; if (rd0 !== 64'h0) $display("FAIL reset_hrdata0: got %h want 0", rd0); else n_pass++;
        n_chk++; if (rd1 !== 64'h0) $display("FAIL reset_hrdata1: got %h want 0", rd1); else n_pass++;
        n_chk++; if ({en0, we0, en1, we1} !== 4'b0000) $display("FAIL reset_sram_ctl: got %b want 0000", {en0, we0, en1, we1}); else n_pass++;
        n_chk++; if ({wm0, wm1} !== 16'h0) $display("FAIL reset_wmask: got %h want 0", {wm0, wm1}); else n_pass++;
        hreset = 1'b0;
        @(negedge HCLK);
    endtask

    task automatic test_write_read();
        logic [63:0] d;
        int cyc;
        d = 64'h1122_3344_5566_7788;
        hsel0 = 1; haddr = 32'h2000_0008; htrans = 2'b10; hwrite = 1; hsize = 3'd3;
        @(negedge HCLK);
        n_chk++; if (ro0 !== 1'b1) $display("FAIL wr_zero_wait: HREADYOUT=%b want 1", ro0); else n_pass++;
        hwdata = d; hwrite = 0;
        @(negedge HCLK);
        hsel0 = 0; htrans = 2'b00;
        n_chk++; if ({en0, we0, wm0, sa0} !== {1'b1, 1'b1, 8'hFF, 10'd1})
            $display("FAIL rd_drain_ctl: got en=%b we=%b mask=%h addr=%0d want 1 1 ff 1", en0, we0, wm0, sa0); else n_pass++;
        n_chk++; if (wd0 !== d) $display("FAIL rd_drain_data: got %h want %h", wd0, d); else n_pass++;
        cyc = 1;
        while (ro0 !== 1'b1 && cyc < 40) begin @(negedge HCLK); cyc++; end
        apply_ref(0, 32'h2000_0008, 3'd3, d);
        n_chk++; if (cyc != 4) $display("FAIL rd_after_wr_len: got %0d cycles want 4", cyc); else n_pass++;
        n_chk++; if (rd0 !== ref0[1]) $display("FAIL rd_after_wr_data: got %h want %h", rd0, ref0[1]); else n_pass++;
        @(negedge HCLK);
    endtask

    task automatic test_byte_write();
        logic [63:0] d;
        d = {$urandom, $urandom};
        d[31:24] = 8'hAB;
        hsel0 = 1; haddr = 32'h2000_0013; htrans = 2'b10; hwrite = 1; hsize = 3'd0;
        @(negedge HCLK);
        hsel0 = 0; htrans = 2'b00; hwdata = d;
        n_chk++; if (ro0 !== 1'b1) $display("FAIL byte_wr_ready: HREADYOUT=%b want 1", ro0); else n_pass++;
        @(negedge HCLK);
        n_chk++; if ({en0, we0, wm0, sa0} !== {1'b1, 1'b1, 8'h08, 10'd2})
            $display("FAIL byte_wr_ctl: got en=%b we=%b mask=%h addr=%0d want 1 1 08 2", en0, we0, wm0, sa0); else n_pass++;
        n_chk++; if (wd0[31:24] !== 8'hAB) $display("FAIL byte_wr_lane: got %h want ab", wd0[31:24]); else n_pass++;
        apply_ref(0, 32'h2000_0013, 3'd0, d);
    endtask

    task automatic test_back_to_back();
        logic [63:0] d0, d1, d2, rdat;
        int cyc, enc;
        bit ra, rany;
        d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom}; d2 = {$urandom, $urandom};
        hsel0 = 1; htrans = 2'b10; hwrite = 1; hsize = 3'd2; haddr = 32'h2000_0000;
        @(negedge HCLK);
        n_chk++; if (ro0 !== 1'b1) $display("FAIL b2b_ready0: HREADYOUT=%b want 1", ro0); else n_pass++;
        hwdata = d0; haddr = 32'h2000_0004;
        @(negedge HCLK);
        n_chk++; if (ro0 !== 1'b1) $display("FAIL b2b_ready1: HREADYOUT=%b want 1", ro0); else n_pass++;
        n_chk++; if ({en0, we0, wm0, sa0} !== {1'b1, 1'b1, 8'h0F, 10'd0} || wd0 !== d0)
            $display("FAIL b2b_drain0: got en=%b we=%b mask=%h addr=%0d data=%h want 1 1 0f 0 %h", en0, we0, wm0, sa0, wd0, d0); else n_pass++;
        hwdata = d1; haddr = 32'h2000_0008;
        @(negedge HCLK);
        n_chk++; if (ro0 !== 1'b1) $display("FAIL b2b_ready2: HREADYOUT=%b want 1", ro0); else n_pass++;
        n_chk++; if ({en0, we0, wm0, sa0} !== {1'b1, 1'b1, 8'hF0, 10'd0} || wd0 !== d1)
            $display("FAIL b2b_drain1: got en=%b we=%b mask=%h addr=%0d data=%h want 1 1 f0 0 %h", en0, we0, wm0, sa0, wd0, d1); else n_pass++;
        hsel0 = 0; htrans = 2'b00; hwdata = d2;
        @(negedge HCLK);
        n_chk++; if ({en0, we0, wm0, sa0} !== {1'b1, 1'b1, 8'h0F, 10'd1} || wd0 !== d2)
            $display("FAIL b2b_drain2: got en=%b we=%b mask=%h addr=%0d data=%h want 1 1 0f 1 %h", en0, we0, wm0, sa0, wd0, d2); else n_pass++;
        apply_ref(0, 32'h2000_0000, 3'd2, d0);
        apply_ref(0, 32'h2000_0004, 3'd2, d1);
        apply_ref(0, 32'h2000_0008, 3'd2, d2);
        @(negedge HCLK);
        n_chk++; if (en0 !== 1'b0) $display("FAIL b2b_idle_en: got %b want 0", en0); else n_pass++;
        xfer(0, 32'h2000_0000, 0, 3'd3, '0, rdat, cyc, ra, rany, enc);
        n_chk++; if (rdat !== ref0[0]) $display("FAIL b2b_readback0: got %h want %h", rdat, ref0[0]); else n_pass++;
        xfer(0, 32'h2000_0008, 0, 3'd3, '0, rdat, cyc, ra, rany, enc);
        n_chk++; if (rdat !== ref0[1]) $display("FAIL b2b_readback1: got %h want %h", rdat, ref0[1]); else n_pass++;
    endtask

    task automatic test_errors();
        logic [63:0] rdat;
        int cyc, enc;
        bit ra, rany;
        xfer(0, 32'h2000_0001, 0, 3'd1, '0, rdat, cyc, ra, rany, enc);
        n_chk++; if (cyc != 2 || !ra || enc != 0)
            $display("FAIL err_misaligned: got cycles=%0d resp_all=%b en=%0d want 2 1 0", cyc, ra, enc); else n_pass++;
        xfer(0, 32'h3000_0000, 0, 3'd2, '0, rdat, cyc, ra, rany, enc);
        n_chk++; if (cyc != 2 || !ra || enc != 0)
            $display("FAIL err_window: got cycles=%0d resp_all=%b en=%0d want 2 1 0", cyc, ra, enc); else n_pass++;
        xfer(0, 32'h2000_0000, 1, 3'd4, {$urandom, $urandom}, rdat, cyc, ra, rany, enc);
        n_chk++; if (cyc != 2 || !ra || enc != 0)
            $display("FAIL err_oversize: got cycles=%0d resp_all=%b en=%0d want 2 1 0", cyc, ra, enc); else n_pass++;
        xfer(0, 32'h2000_0000, 0, 3'd3, '0, rdat, cyc, ra, rany, enc);
        n_chk++; if (rdat !== ref0[0] || rany)
            $display("FAIL err_no_write: got %h resp=%b want %h 0", rdat, rany, ref0[0]); else n_pass++;
    endtask

    task automatic test_wait_states();
        logic [63:0] d, rdat;
        int cyc, enc;
        bit ra, rany;
        d = {$urandom, $urandom};
        xfer(1, 32'h2000_0000, 1, 3'd3, d, rdat, cyc, ra, rany, enc);
        apply_ref(1, 32'h2000_0000, 3'd3, d);
        xfer(1, 32'h2000_0000, 0, 3'd3, '0, rdat, cyc, ra, rany, enc);
        n_chk++; if (cyc != 6) $display("FAIL ws3_len: got %0d cycles want 6", cyc); else n_pass++;
        n_chk++; if (rdat !== ref1[0]) $display("FAIL ws3_data: got %h want %h", rdat, ref1[0]); else n_pass++;
        n_chk++; if (enc != 1 || rany) $display("FAIL ws3_strobe: got en=%0d resp=%b want 1 0", enc, rany); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        logic [63:0] d, rdat;
        int cyc, enc, snap;
        bit ra, rany;
        hsel1 = 1; haddr = 32'h2000_0000; htrans = 2'b10; hwrite = 0; hsize = 3'd3;
        @(negedge HCLK);
        hsel1 = 0; htrans = 2'b00;
        @(negedge HCLK);
        hreset = 1'b1;
        #1;
        n_chk++; if (ro1 !== 1'b1 || rs1 !== 1'b0) $display("FAIL rst_mid_read: got ready=%b resp=%b want 1 0", ro1, rs1); else n_pass++;
        @(negedge HCLK);
        n_chk++; if (en1 !== 1'b0) $display("FAIL rst_mid_read_en: got %b want 0", en1); else n_pass++;
        hreset = 1'b0;
        @(negedge HCLK);
        d = {$urandom, $urandom};
        hsel1 = 1; haddr = 32'h2000_0010; htrans = 2'b10; hwrite = 1; hsize = 3'd3;
        @(negedge HCLK);
        hsel1 = 0; htrans = 2'b00; hwdata = d;
        @(posedge HCLK);
        #1 hreset = 1'b1;
        snap = wr_cnt1;
        @(negedge HCLK);
        n_chk++; if (en1 !== 1'b0) $display("FAIL rst_buf_en: got %b want 0", en1); else n_pass++;
        hreset = 1'b0;
        repeat (3) @(negedge HCLK);
        n_chk++; if (wr_cnt1 != snap) $display("FAIL rst_buf_discard: got %0d sram writes want %0d", wr_cnt1, snap); else n_pass++;
        xfer(1, 32'h2000_0010, 0, 3'd3, '0, rdat, cyc, ra, rany, enc);
        n_chk++; if (rdat !== ref1[2]) $display("FAIL rst_buf_data: got %h want %h", rdat, ref1[2]); else n_pass++;
    endtask

    task automatic test_random();
        logic [63:0] d, rdat, exp_d;
        logic [31:0] a;
        logic [2:0]  sz;
        int cyc, enc, widx, off, exp_cyc;
        bit inst, w, out, exp_err, ra, rany;
        for (int it = 0; it < 60; it++) begin
            inst = 1'($urandom % 2);
            widx = int'($urandom % 16);
            off  = int'($urandom % 8);
            sz   = ($urandom % 8 == 0) ? 3'(4 + $urandom % 4) : 3'($urandom % 4);
            if (sz <= 3'd3 && ($urandom % 4) != 0) off = off - (off % (1 << sz));
            out  = ($urandom % 6 == 0);
            a    = (out ? 32'h4000_0000 : 32'h2000_0000) + 32'(widx * 8 + off);
            w    = 1'($urandom % 2);
            d    = {$urandom, $urandom};
            exp_err = ((a >> 13) != (32'h2000_0000 >> 13)) || (sz > 3'd3) || ((a % (1 << sz)) != 0);
            exp_d   = inst ? ref1[widx] : ref0[widx];
            xfer(inst, a, w, sz, d, rdat, cyc, ra, rany, enc);
            if (exp_err) begin
                n_chk++; if (cyc != 2 || !ra || enc != 0)
                    $display("FAIL rnd_err it=%0d a=%h sz=%0d: got cycles=%0d resp_all=%b en=%0d want 2 1 0", it, a, sz, cyc, ra, enc); else n_pass++;
            end else if (w) begin
                n_chk++; if (cyc != 1 || rany)
                    $display("FAIL rnd_wr it=%0d a=%h: got cycles=%0d resp=%b want 1 0", it, a, cyc, rany); else n_pass++;
                apply_ref(inst, a, sz, d);
            end else begin
                exp_cyc = inst ? 6 : 3;
                n_chk++; if (cyc != exp_cyc || rany)
                    $display("FAIL rnd_rd_len it=%0d a=%h: got cycles=%0d resp=%b want %0d 0", it, a, cyc, rany, exp_cyc); else n_pass++;
                n_chk++; if (rdat !== exp_d)
                    $display("FAIL rnd_rd_data it=%0d a=%h: got %h want %h", it, a, rdat, exp_d); else n_pass++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ref0[i] = '0;
            ref1[i] = '0;
        end
        test_reset();
        test_write_read();
        test_byte_write();
        test_back_to_back();
        test_errors();
        test_wait_states();
        test_reset_mid_read();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
